dmem_arbiter: RTL and testbench

//  Shares the core's single data-memory port (wr/rd/addr/wr_data/rd_data) between two requesters.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Data-memory sharing bus: core (c_*) and loader/DMA (d_*) requesters plus the single memory port (m_*).
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;
  logic              c_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              m_wr;
  logic              m_rd;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] m_rd_data;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_rd_data,
    output c_ack, c_rdata, c_stall,
    output d_ack, d_rdata,
    output m_wr, m_rd, m_addr, m_wr_data
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output m_rd_data,
    input  c_ack, c_rdata, c_stall,
    input  d_ack, d_rdata,
    input  m_wr, m_rd, m_addr, m_wr_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (C fixed priority, D anti-starvation); ack at t+MEM_LAT+2, one access in flight.
// Backpressure: requesters hold req until ack, core stalled meanwhile; ARB_PERF_EN adds perf_stall_cnt.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [15:0]   perf_stall_cnt
`endif
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              owner_d_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic starve;
  logic grant_c;
  logic grant_d;
  logic lat_last;
  logic m_rd_c;
  logic m_wr_c;
  logic c_ack_c;
  logic d_ack_c;

  // D only overtakes C once C has been granted STARVE_LIM times back to back while D waited.
  assign starve   = (starve_cnt == SC_W'(STARVE_LIM));
  assign grant_d  = bus.d_req & (~bus.c_req | starve);
  assign grant_c  = bus.c_req & ~grant_d;
  assign lat_last = (lat_cnt == LAT_W'(MEM_LAT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_rd_c  = 1'b0;
    m_wr_c  = 1'b0;
    c_ack_c = 1'b0;
    d_ack_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.c_req | bus.d_req) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        m_rd_c  = ~we_q;
        m_wr_c  = we_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        c_ack_c = ~owner_d_q;
        d_ack_c = owner_d_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction latch, latency counter and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_cnt   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && (grant_c || grant_d)) begin
        owner_d_q <= grant_d;
        we_q      <= grant_d ? bus.d_we    : bus.c_we;
        addr_q    <= grant_d ? bus.d_addr  : bus.c_addr;
        wdata_q   <= grant_d ? bus.d_wdata : bus.c_wdata;
      end
      if (state_q == ST_ISSUE) begin
        lat_cnt <= '0;
      end else if (state_q == ST_WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      // Landing data straight in the owner's register makes it valid in the RESP cycle.
      if (state_q == ST_WAIT && lat_last && !we_q) begin
        if (owner_d_q) begin
          d_rdata_q <= bus.m_rd_data;
        end else begin
          c_rdata_q <= bus.m_rd_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!bus.d_req) begin
      starve_cnt <= '0;
    end else if (state_q == ST_IDLE) begin
      if (grant_d) begin
        starve_cnt <= '0;
      end else if (grant_c && !starve) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign bus.m_rd      = m_rd_c;
  assign bus.m_wr      = m_wr_c;
  assign bus.m_addr    = addr_q;
  assign bus.m_wr_data = wdata_q;
  assign bus.c_ack     = c_ack_c;
  assign bus.d_ack     = d_ack_c;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  // Gated by reset so every output reads 0 while reset is held, even with c_req high.
  assign bus.c_stall   = reset & bus.c_req & ~c_ack_c;

`ifdef ARB_PERF_EN
  logic [15:0] perf_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt_q <= '0;
    end else if (bus.c_stall && perf_cnt_q != 16'hFFFF) begin
      perf_cnt_q <= perf_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table on a MEM_LAT=1 instance, hand sequences for
// arbitration, starvation, reset abort (MEM_LAT=3 instance) and the optional stall counter.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(9)) b1 ();
  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(9)) b3 ();

`ifdef ARB_PERF_EN
  logic [15:0] perf1;
  logic [15:0] perf3;
`endif

  dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(1), .STARVE_LIM(4)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
`ifdef ARB_PERF_EN
    , .perf_stall_cnt(perf1)
`endif
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(3), .STARVE_LIM(4)) dut3 (
    .clk(clk), .reset(reset), .bus(b3)
`ifdef ARB_PERF_EN
    , .perf_stall_cnt(perf3)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic        mem_mode;
  logic [31:0] tbl_rd;

  function automatic logic [31:0] mem_f(input logic [8:0] a);
    return 32'hC0DE0000 ^ {23'h0, a};
  endfunction

  always_comb b1.m_rd_data = mem_mode ? mem_f(b1.m_addr) : tbl_rd;
  always_comb b3.m_rd_data = mem_f(b3.m_addr);

  typedef struct packed {
    logic         c_req;
    logic         c_we;
    logic [8:0]   c_addr;
    logic [31:0]  c_wdata;
    logic         d_req;
    logic         d_we;
    logic [8:0]   d_addr;
    logic [31:0]  d_wdata;
    logic [31:0]  mrd;
    logic [109:0] exp;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
    input logic dr, input logic dw, input logic [8:0] da, input logic [31:0] dd,
    input logic [31:0] mrd,
    input logic e_rd, input logic e_wr, input logic [8:0] e_addr, input logic [31:0] e_wd,
    input logic e_cack, input logic [31:0] e_crd, input logic e_stall,
    input logic e_dack, input logic [31:0] e_drd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.mrd = mrd;
    v.exp = {e_rd, e_wr, e_addr, e_wd, e_cack, e_crd, e_stall, e_dack, e_drd};
    return v;
  endfunction

  function automatic logic [109:0] out1();
    return {b1.m_rd, b1.m_wr, b1.m_addr, b1.m_wr_data, b1.c_ack, b1.c_rdata, b1.c_stall, b1.d_ack, b1.d_rdata};
  endfunction

  function automatic logic [109:0] out3();
    return {b3.m_rd, b3.m_wr, b3.m_addr, b3.m_wr_data, b3.c_ack, b3.c_rdata, b3.c_stall, b3.d_ack, b3.d_rdata};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    b1.c_req = v.c_req; b1.c_we = v.c_we; b1.c_addr = v.c_addr; b1.c_wdata = v.c_wdata;
    b1.d_req = v.d_req; b1.d_we = v.d_we; b1.d_addr = v.d_addr; b1.d_wdata = v.d_wdata;
    tbl_rd = v.mrd;
  endtask

`ifdef ARB_PERF_EN
  task automatic c_read1(input logic [8:0] a);
    bit got = 0;
    @(posedge clk); #1;
    b1.c_req = 1'b1; b1.c_we = 1'b0; b1.c_addr = a;
    for (int k = 0; k < 10 && !got; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (b1.c_ack) got = 1;
    end
    @(posedge clk); #1;
    b1.c_req = 1'b0;
    if (!got) chk("perf_read_ack_timeout", 0, 1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    bit   ack_seq[$];
    int   sc, sd, nc, nd, conc, first_d, bad, ack_at;
    bit   c_done, d_done;
    logic [31:0] rd_at_ack;

    reset = 1'b0;
    mem_mode = 1'b0;
    tbl_rd = '0;
    b1.c_req = 0; b1.c_we = 0; b1.c_addr = '0; b1.c_wdata = '0;
    b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.c_req = 0; b3.c_we = 0; b3.c_addr = '0; b3.c_wdata = '0;
    b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state_dut1", out1(), 0);
    chk("reset_state_dut3", out3(), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // C read, D write, D read, C write; one row per cycle.
    tbl.push_back(mk(1,0,9'h010,0,            0,0,0,0,            0,            0,0,9'h000,0,            0,0,1,0,0));
    tbl.push_back(mk(1,0,9'h010,0,            0,0,0,0,            0,            1,0,9'h010,0,            0,0,1,0,0));
    tbl.push_back(mk(1,0,9'h010,0,            0,0,0,0,            32'hDEADBEEF, 0,0,9'h010,0,            0,0,1,0,0));
    tbl.push_back(mk(1,0,9'h010,0,            0,0,0,0,            32'hDEADBEEF, 0,0,9'h010,0,            1,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 0,0,0,0,            0,            0,0,9'h010,0,            0,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 1,1,9'h1FF,32'hA5A5A5A5, 0,       0,0,9'h010,0,            0,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 1,1,9'h1FF,32'hA5A5A5A5, 0,       0,1,9'h1FF,32'hA5A5A5A5, 0,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 1,1,9'h1FF,32'hA5A5A5A5, 32'h12345678, 0,0,9'h1FF,32'hA5A5A5A5, 0,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 1,1,9'h1FF,32'hA5A5A5A5, 32'h12345678, 0,0,9'h1FF,32'hA5A5A5A5, 0,32'hDEADBEEF,0,1,0));
    tbl.push_back(mk(0,0,0,0,                 0,0,0,0,            0,            0,0,9'h1FF,32'hA5A5A5A5, 0,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 1,0,9'h055,0,       0,            0,0,9'h1FF,32'hA5A5A5A5, 0,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 1,0,9'h055,0,       0,            1,0,9'h055,0,            0,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 1,0,9'h055,0,       32'hCAFEF00D, 0,0,9'h055,0,            0,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,                 1,0,9'h055,0,       32'hCAFEF00D, 0,0,9'h055,0,            0,32'hDEADBEEF,0,1,32'hCAFEF00D));
    tbl.push_back(mk(0,0,0,0,                 0,0,0,0,            0,            0,0,9'h055,0,            0,32'hDEADBEEF,0,0,32'hCAFEF00D));
    tbl.push_back(mk(1,1,9'h0AA,32'h11223344, 0,0,0,0,            0,            0,0,9'h055,0,            0,32'hDEADBEEF,1,0,32'hCAFEF00D));
    tbl.push_back(mk(1,1,9'h0AA,32'h11223344, 0,0,0,0,            0,            0,1,9'h0AA,32'h11223344, 0,32'hDEADBEEF,1,0,32'hCAFEF00D));
    tbl.push_back(mk(1,1,9'h0AA,32'h11223344, 0,0,0,0,            32'h77777777, 0,0,9'h0AA,32'h11223344, 0,32'hDEADBEEF,1,0,32'hCAFEF00D));
    tbl.push_back(mk(1,1,9'h0AA,32'h11223344, 0,0,0,0,            32'h77777777, 0,0,9'h0AA,32'h11223344, 1,32'hDEADBEEF,0,0,32'hCAFEF00D));
    tbl.push_back(mk(0,0,0,0,                 0,0,0,0,            0,            0,0,9'h0AA,32'h11223344, 0,32'hDEADBEEF,0,0,32'hCAFEF00D));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive1(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d", i), out1(), tbl[i].exp);
    end

    // Simultaneous requests: C first, D strobe MEM_LAT+3 cycles later.
    mem_mode = 1'b1;
    sc = -1; sd = -1; nc = 0; nd = 0; conc = 0; first_d = -1;
    c_done = 0; d_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        b1.c_req = 1; b1.c_we = 0; b1.c_addr = 9'h020;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 9'h030;
      end
      if (c_done) b1.c_req = 0;
      if (d_done) b1.d_req = 0;
      @(negedge clk);
      if (b1.m_rd && b1.m_addr == 9'h020 && sc < 0) sc = k;
      if (b1.m_rd && b1.m_addr == 9'h030 && sd < 0) sd = k;
      if (b1.c_ack && b1.d_ack) conc++;
      if (b1.c_ack) begin nc++; c_done = 1; if (first_d < 0) first_d = 0; end
      if (b1.d_ack) begin nd++; d_done = 1; if (first_d < 0) first_d = 1; end
    end
    chk("simul_first_ack_is_c", first_d, 0);
    chk("simul_strobe_spacing", sd - sc, 4);
    chk("simul_c_ack_count", nc, 1);
    chk("simul_d_ack_count", nd, 1);
    chk("simul_no_concurrent_ack", conc, 0);
    chk("simul_c_rdata", b1.c_rdata, mem_f(9'h020));
    chk("simul_d_rdata", b1.d_rdata, mem_f(9'h030));

    // Both held high: four C grants, then D, repeating.
    conc = 0;
    @(posedge clk); #1;
    b1.c_req = 1; b1.c_we = 0; b1.c_addr = 9'h100;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 9'h101;
    for (int k = 0; k < 48 && ack_seq.size() < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (b1.c_ack && b1.d_ack) conc++;
      if (b1.c_ack) ack_seq.push_back(1'b0);
      if (b1.d_ack) ack_seq.push_back(1'b1);
    end
    @(posedge clk); #1;
    b1.c_req = 0; b1.d_req = 0;
    chk("starve_ack_count", ack_seq.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < ack_seq.size()) chk($sformatf("starve_ack%0d_is_d", i), ack_seq[i], (i == 4 || i == 9) ? 1 : 0);
    end
    chk("starve_no_concurrent_ack", conc, 0);
    repeat (8) @(posedge clk);

    // Reset in the second WAIT cycle of a MEM_LAT=3 read.
    @(posedge clk); #1;
    b3.c_req = 1; b3.c_we = 0; b3.c_addr = 9'h040;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_issue_strobe", {b3.m_rd, b3.m_addr}, {1'b1, 9'h040});
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_outputs_zero", out3(), 0);
    b3.c_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b3.c_ack || b3.m_rd) bad++;
    end
    chk("abort_no_ack_after_release", bad, 0);

    @(posedge clk); #1;
    b3.c_req = 1; b3.c_we = 0; b3.c_addr = 9'h040;
    ack_at = -1; nc = 0; rd_at_ack = '0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (ack_at >= 0) b3.c_req = 0;
      end
      @(negedge clk);
      if (b3.c_ack) begin
        nc++;
        if (ack_at < 0) begin ack_at = k; rd_at_ack = b3.c_rdata; end
      end
    end
    chk("reissue_ack_cycle", ack_at, 5);
    chk("reissue_ack_count", nc, 1);
    chk("reissue_rdata", rd_at_ack, mem_f(9'h040));

`ifdef ARB_PERF_EN
    c_read1(9'h010);
    @(negedge clk);
    chk("perf_three_stalls", perf1, 16'd3);
    @(posedge clk); #1;
    force dut1.perf_cnt_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut1.perf_cnt_q;
    c_read1(9'h011);
    c_read1(9'h012);
    @(negedge clk);
    chk("perf_saturate", perf1, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
